fir_peak_monitor: RTL and testbench

Streaming response monitor on the output side of the pipelined FIR filter. Consumes the filter's y_out/y_valid stream and partitions accepted samples into fixed windows of WIN_LEN. For each window it reports max, min, peak magnitude, sum of magnitudes and a window index, so a sweep run yields a measured magnitude response without dumping every sample. Results leave on a valid/ready port with one-entry buffering and overflow detection.

---
 rtl/fir_peak_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_fir_peak_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_peak_monitor.sv
// -----------------------------------------------------------------------------
// fir_peak_monitor
//
// Watches the output stream of the pipelined FIR filter and reduces it to one
// summary record per window of WIN_LEN accepted samples: signed max, signed min,
// peak magnitude, sum of magnitudes and a running window index. Records leave
// through a one-entry valid/ready output register. A record that completes
// while the register is still held (consumer not ready) is dropped and the
// sticky overflow flag is raised.
//
// Parameters
//   DATA_W   sample width, signed two's complement
//   WIN_LEN  accepted samples per window, power of two, 2..4096
//   IDX_W    window index width (wraps)
//   SUM_W    magnitude-sum width, derived as DATA_W + log2(WIN_LEN)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active HIGH (legacy name kept)
//   y_in         filter output sample, signed
//   y_valid      y_in is valid this cycle (no input backpressure)
//   clear        synchronous restart of windowing, index, overflow and output
//   res_valid    a result record is held in the output register
//   res_ready    consumer accepts the held record
//   res_max      largest signed sample of the window
//   res_min      smallest signed sample of the window
//   res_peak     largest saturated magnitude of the window, unsigned
//   res_sum_abs  sum of saturated magnitudes of the window, unsigned
//   res_index    window number since reset/clear
//   overflow     sticky: a completed window was dropped
// -----------------------------------------------------------------------------
module fir_peak_monitor #(
  parameter  int DATA_W  = 32,
  parameter  int WIN_LEN = 64,
  parameter  int IDX_W   = 16,
  localparam int SUM_W   = DATA_W + $clog2(WIN_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] y_in,
  input  logic              y_valid,
  input  logic              clear,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_max,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_peak,
  output logic [SUM_W-1:0]  res_sum_abs,
  output logic [IDX_W-1:0]  res_index,
  output logic              overflow
);

  localparam int CNT_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIN_LEN - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Window accumulators
  logic        [CNT_W-1:0]  cnt_q,      cnt_d;
  logic signed [DATA_W-1:0] run_max_q,  run_max_d;
  logic signed [DATA_W-1:0] run_min_q,  run_min_d;
  logic        [DATA_W-1:0] run_peak_q, run_peak_d;
  logic        [SUM_W-1:0]  run_sum_q,  run_sum_d;
  logic        [IDX_W-1:0]  win_idx_q,  win_idx_d;

  // Output register
  out_state_e               state_q,    state_d;
  logic        [DATA_W-1:0] res_max_q,  res_max_d;
  logic        [DATA_W-1:0] res_min_q,  res_min_d;
  logic        [DATA_W-1:0] res_peak_q, res_peak_d;
  logic        [SUM_W-1:0]  res_sum_q,  res_sum_d;
  logic        [IDX_W-1:0]  res_idx_q,  res_idx_d;
  logic                     overflow_q, overflow_d;

  // Per-sample intermediates
  logic signed [DATA_W-1:0] y_s;
  logic        [DATA_W-1:0] y_abs;
  logic                     accept;
  logic                     first;
  logic                     complete;
  logic signed [DATA_W-1:0] nxt_max;
  logic signed [DATA_W-1:0] nxt_min;
  logic        [DATA_W-1:0] nxt_peak;
  logic        [SUM_W-1:0]  nxt_sum;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    y_s      = $signed(y_in);
    y_abs    = y_in;
    accept   = y_valid & ~clear;
    first    = (cnt_q == '0);
    complete = accept && (cnt_q == LAST_CNT);

    // The most negative code has no positive twin; clamp it to the largest
    // positive value so the magnitude always fits in DATA_W unsigned bits.
    if (y_in == MOST_NEG) begin
      y_abs = MOST_POS;
    end else if (y_in[DATA_W-1]) begin
      y_abs = '0 - y_in;
    end

    // Values including the current sample; the first sample of a window
    // loads directly so stale values from the previous window never leak in.
    if (first) begin
      nxt_max  = y_s;
      nxt_min  = y_s;
      nxt_peak = y_abs;
      nxt_sum  = SUM_W'(y_abs);
    end else begin
      nxt_max  = (y_s > run_max_q) ? y_s : run_max_q;
      nxt_min  = (y_s < run_min_q) ? y_s : run_min_q;
      nxt_peak = (y_abs > run_peak_q) ? y_abs : run_peak_q;
      nxt_sum  = run_sum_q + SUM_W'(y_abs);
    end

    cnt_d      = cnt_q;
    run_max_d  = run_max_q;
    run_min_d  = run_min_q;
    run_peak_d = run_peak_q;
    run_sum_d  = run_sum_q;
    win_idx_d  = win_idx_q;
    state_d    = state_q;
    res_max_d  = res_max_q;
    res_min_d  = res_min_q;
    res_peak_d = res_peak_q;
    res_sum_d  = res_sum_q;
    res_idx_d  = res_idx_q;
    overflow_d = overflow_q;

    if (accept) begin
      cnt_d      = complete ? '0 : cnt_q + CNT_W'(1);
      run_max_d  = nxt_max;
      run_min_d  = nxt_min;
      run_peak_d = nxt_peak;
      run_sum_d  = nxt_sum;
    end

    if (complete) begin
      // The index counts every completed window, delivered or dropped.
      win_idx_d = win_idx_q + IDX_W'(1);
      // The register may take a new record when it is empty or when the held
      // record leaves on this same edge; otherwise the new one is lost.
      if (state_q == OUT_EMPTY || res_ready) begin
        state_d    = OUT_FULL;
        res_max_d  = nxt_max;
        res_min_d  = nxt_min;
        res_peak_d = nxt_peak;
        res_sum_d  = nxt_sum;
        res_idx_d  = win_idx_q;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (state_q == OUT_FULL && res_ready) begin
      state_d = OUT_EMPTY;
    end

    if (clear) begin
      cnt_d      = '0;
      run_max_d  = '0;
      run_min_d  = '0;
      run_peak_d = '0;
      run_sum_d  = '0;
      win_idx_d  = '0;
      state_d    = OUT_EMPTY;
      res_max_d  = '0;
      res_min_d  = '0;
      res_peak_d = '0;
      res_sum_d  = '0;
      res_idx_d  = '0;
      overflow_d = 1'b0;
    end
  end

  // Reset is asserted high here despite the _n suffix of the legacy name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q      <= '0;
      run_max_q  <= '0;
      run_min_q  <= '0;
      run_peak_q <= '0;
      run_sum_q  <= '0;
      win_idx_q  <= '0;
      state_q    <= OUT_EMPTY;
      res_max_q  <= '0;
      res_min_q  <= '0;
      res_peak_q <= '0;
      res_sum_q  <= '0;
      res_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order or of other processes on this edge.
      cnt_q      <= cnt_d;
      run_max_q  <= run_max_d;
      run_min_q  <= run_min_d;
      run_peak_q <= run_peak_d;
      run_sum_q  <= run_sum_d;
      win_idx_q  <= win_idx_d;
      state_q    <= state_d;
      res_max_q  <= res_max_d;
      res_min_q  <= res_min_d;
      res_peak_q <= res_peak_d;
      res_sum_q  <= res_sum_d;
      res_idx_q  <= res_idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign res_valid   = (state_q == OUT_FULL);
  assign res_max     = res_max_q;
  assign res_min     = res_min_q;
  assign res_peak    = res_peak_q;
  assign res_sum_abs = res_sum_q;
  assign res_index   = res_idx_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fir_peak_monitor.sv
// -----------------------------------------------------------------------------
// tb_fir_peak_monitor
//
// Bench for fir_peak_monitor with WIN_LEN=4. A reference model collects the
// accepted samples of each window in a queue, computes the window statistics
// with plain arithmetic once the window is full, and pushes the expected record
// into a scoreboard queue. A separate monitor pops and compares whenever the
// DUT hands a record over, and also tracks res_valid/overflow every cycle.
// Directed sequences cover the documented scenarios; random traffic follows.
// -----------------------------------------------------------------------------
module tb_fir_peak_monitor;

  localparam int DATA_W  = 32;
  localparam int WIN_LEN = 4;
  localparam int IDX_W   = 16;
  localparam int SUM_W   = DATA_W + $clog2(WIN_LEN);

  localparam longint MIN_S = -(longint'(1) << (DATA_W - 1));
  localparam longint MAX_S = (longint'(1) << (DATA_W - 1)) - 1;

  typedef struct {
    longint mx;
    longint mn;
    longint pk;
    longint sm;
    longint idx;
  } res_t;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] y_in;
  logic              y_valid;
  logic              clear;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_max;
  logic [DATA_W-1:0] res_min;
  logic [DATA_W-1:0] res_peak;
  logic [SUM_W-1:0]  res_sum_abs;
  logic [IDX_W-1:0]  res_index;
  logic              overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  longint     win[$];
  res_t       exp_q[$];
  bit         m_pending;
  bit         m_ovf;
  logic [IDX_W-1:0] m_idx;
  bit         m_comp;
  bit         m_xfer;
  res_t       m_r;
  res_t       got_r;

  fir_peak_monitor #(
    .DATA_W  (DATA_W),
    .WIN_LEN (WIN_LEN),
    .IDX_W   (IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .y_in        (y_in),
    .y_valid     (y_valid),
    .clear       (clear),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_max     (res_max),
    .res_min     (res_min),
    .res_peak    (res_peak),
    .res_sum_abs (res_sum_abs),
    .res_index   (res_index),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic longint sat_abs(input longint v);
    if (v == MIN_S) return MAX_S;
    return (v < 0) ? -v : v;
  endfunction

  function automatic res_t stats(input longint w[$]);
    res_t r;
    r.mx = w[0];
    r.mn = w[0];
    r.pk = 0;
    r.sm = 0;
    r.idx = 0;
    foreach (w[i]) begin
      if (w[i] > r.mx) r.mx = w[i];
      if (w[i] < r.mn) r.mn = w[i];
      if (sat_abs(w[i]) > r.pk) r.pk = sat_abs(w[i]);
      r.sm += sat_abs(w[i]);
    end
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.mx  = longint'($signed(res_max));
    r.mn  = longint'($signed(res_min));
    r.pk  = longint'(res_peak);
    r.sm  = longint'(res_sum_abs);
    r.idx = longint'(res_index);
    return r;
  endfunction

  task automatic check_res(input string name, input res_t e);
    res_t g;
    g = dut_res();
    check({name, "_max"},   g.mx,  e.mx);
    check({name, "_min"},   g.mn,  e.mn);
    check({name, "_peak"},  g.pk,  e.pk);
    check({name, "_sum"},   g.sm,  e.sm);
    check({name, "_index"}, g.idx, e.idx);
  endtask

  task automatic check_zero(input string name);
    res_t z;
    z = '{0, 0, 0, 0, 0};
    check({name, "_valid"},    longint'(res_valid), 0);
    check({name, "_overflow"}, longint'(overflow),  0);
    check_res(name, z);
  endtask

  // Reference model: effect of each rising edge, from the inputs the DUT sees.
  always @(posedge clk) begin
    if (rst_n || clear) begin
      win.delete();
      exp_q.delete();
      m_pending = 1'b0;
      m_ovf     = 1'b0;
      m_idx     = '0;
    end else begin
      m_comp = 1'b0;
      m_xfer = m_pending && res_ready;
      if (y_valid) begin
        win.push_back(longint'($signed(y_in)));
        if (win.size() == WIN_LEN) begin
          m_comp = 1'b1;
          m_r    = stats(win);
          win.delete();
        end
      end
      if (m_comp) begin
        if (!m_pending || res_ready) begin
          m_r.idx = longint'(m_idx);
          exp_q.push_back(m_r);
          m_pending = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
        m_idx = m_idx + 1'b1;
      end else if (m_xfer) begin
        m_pending = 1'b0;
      end
    end
  end

  // Monitor: outputs are stable at the falling edge; a handshake seen here
  // completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n && !clear) begin
      check("res_valid", longint'(res_valid), longint'(m_pending));
      check("overflow",  longint'(overflow),  longint'(m_ovf));
      if (res_valid && res_ready) begin
        check("result_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          got_r = exp_q.pop_front();
          check_res("sb", got_r);
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [DATA_W-1:0] y, input bit rdy, input bit clr);
    y_valid   = v;
    y_in      = y;
    res_ready = rdy;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_sample();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(DATA_W-1){1'b0}}};
      1:       return {1'b0, {(DATA_W-1){1'b1}}};
      2:       return DATA_W'($urandom_range(0, 200)) - DATA_W'(100);
      default: return DATA_W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] s [4];
    longint            w[$];
    res_t              e;

    rst_n     = 1'b1;
    y_valid   = 1'b0;
    y_in      = '0;
    clear     = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b0;
    drive(0, 0, 1, 0);

    // Basic window, then the next index
    drive(1, 100, 1, 0);
    drive(1, -300, 1, 0);
    drive(1, 50, 1, 0);
    drive(1, 200, 1, 0);
    check("basic_valid", longint'(res_valid), 1);
    check_res("basic", '{200, -300, 300, 650, 0});
    drive(1, 1, 1, 0);
    drive(1, 2, 1, 0);
    drive(1, 3, 1, 0);
    drive(1, 4, 1, 0);
    check_res("second", '{4, 1, 4, 10, 1});

    // Most negative sample saturates in magnitude
    drive(1, {1'b1, {(DATA_W-1){1'b0}}}, 1, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 0);
    check_res("sat", '{1, MIN_S, MAX_S, MAX_S + 3, 2});

    // Backpressure over three windows
    drive(0, 0, 0, 1);
    for (int k = 0; k < 12; k++) drive(1, DATA_W'(10 * (k / 4 + 1)), 0, 0);
    check("bp_valid", longint'(res_valid), 1);
    check("bp_overflow", longint'(overflow), 1);
    check_res("bp_held", '{10, 10, 10, 40, 0});
    drive(0, 0, 1, 0);
    check("bp_drained", longint'(res_valid), 0);
    for (int k = 0; k < 4; k++) drive(1, DATA_W'(k + 7), 1, 0);
    check_res("bp_next", '{10, 7, 10, 34, 3});

    // Bubbles between samples, then the same samples back to back
    drive(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) s[k] = rand_sample();
    w.delete();
    for (int k = 0; k < 4; k++) w.push_back(longint'($signed(s[k])));
    e = stats(w);
    for (int k = 0; k < 4; k++) begin
      drive(1, s[k], 0, 0);
      if (k < 3) repeat ($urandom_range(1, 3)) drive(0, rand_sample(), 0, 0);
    end
    e.idx = 0;
    check_res("bubble", e);
    drive(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) drive(1, s[k], 1, 0);
    e.idx = 1;
    check_res("b2b", e);

    // Completion on the same edge as a handshake
    drive(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) drive(1, rand_sample(), 0, 0);
    for (int k = 0; k < 3; k++) drive(1, DATA_W'(k + 1), 0, 0);
    drive(1, 9, 1, 0);
    check("simul_valid", longint'(res_valid), 1);
    check("simul_overflow", longint'(overflow), 0);
    check_res("simul", '{9, 1, 9, 15, 1});
    drive(0, 0, 1, 0);

    // clear mid-window discards the partial window and the clear-edge sample
    drive(1, 11, 1, 0);
    drive(1, 12, 1, 0);
    drive(1, 99, 1, 1);
    check_zero("clear");
    drive(1, 5, 0, 0);
    drive(1, 6, 0, 0);
    drive(1, 7, 0, 0);
    drive(1, 8, 0, 0);
    check_res("after_clear", '{8, 5, 8, 26, 0});
    drive(0, 0, 1, 0);

    // Reset mid-window with a held record and overflow set
    for (int k = 0; k < 10; k++) drive(1, rand_sample(), 0, 0);
    check("pre_reset_overflow", longint'(overflow), 1);
    y_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1, -4, 1, 0);
    drive(1, 3, 1, 0);
    drive(1, -2, 1, 0);
    drive(1, 1, 1, 0);
    check_res("post_reset", '{3, -4, 4, 10, 0});

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 9) < 7), rand_sample(), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
    end

    repeat (3) drive(0, 0, 1, 0);
    check("drain_queue_empty", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
